// File: rtl/asip_control_unit_if.sv
// asip_control_unit_if: fetch, data-memory and MODEX handshake bundle of the ASIP core
//   imem_addr/imem_rdata : instruction ROM address (pc) and combinational read data
//   dmem_req/dmem_we     : data memory request (held until ack) and store/load select
//   dmem_ack             : data memory acknowledge
//   mdr_we               : capture load data into the memory data register
//   modex_start/done     : MODEX coprocessor start pulse and completion
interface asip_control_unit_if #(
    parameter int ARQ = 16,
    parameter int AW  = 13
);
    logic [AW-1:0]  imem_addr;
    logic [ARQ-1:0] imem_rdata;
    logic           dmem_req;
    logic           dmem_we;
    logic           dmem_ack;
    logic           mdr_we;
    logic           modex_start;
    logic           modex_done;

    modport master (
        output imem_addr, dmem_req, dmem_we, mdr_we, modex_start,
        input  imem_rdata, dmem_ack, modex_done
    );

    modport slave (
        input  imem_addr, dmem_req, dmem_we, mdr_we, modex_start,
        output imem_rdata, dmem_ack, modex_done
    );
endinterface

// File: rtl/asip_control_unit.sv
// asip_control_unit: multi-cycle fetch/decode/execute/writeback sequencer of the RSA ASIP core
//   clk, rst      : core clock, synchronous active-high reset
//   start         : begin a run from pc=0 (IDLE/DONE only)
//   bus           : instruction fetch, data memory and MODEX handshakes (master side)
//   ir            : instruction register, feeds the decoder
//   alu_eq        : src1 == src2 compare result, latched by CMPEQ
//   rf_we, wb_sel : register-file write pulse and writeback source (0 imm, 1 add, 2 modex, 3 mdr)
//   busy/done/err : running / finished / timed out (err sticky until rst)
module asip_control_unit #(
    parameter int ARQ      = 16,
    parameter int AW       = 13,
    parameter int PROG_LEN = 8191,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    asip_control_unit_if.master  bus,
    output logic [ARQ-1:0]       ir,
    input  logic                 alu_eq,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_SET   = 3'b000;
    localparam logic [2:0] OP_LDPX  = 3'b001;
    localparam logic [2:0] OP_MODEX = 3'b010;
    localparam logic [2:0] OP_STPX  = 3'b011;
    localparam logic [2:0] OP_CMPEQ = 3'b100;
    localparam logic [2:0] OP_JEQ   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b111;

    typedef enum logic [3:0] {IDLE, FETCH, DECODE, EXEC, MEMW, MODW, WB, DONE, ERR} state_t;

    state_t          state_q;
    logic [AW-1:0]   pc_q;
    logic [ARQ-1:0]  ir_q;
    logic            flag_q;
    logic [CW-1:0]   cnt_q;
    logic            rf_we_q, req_q, we_q, mstart_q, busy_q, done_q, err_q;
    logic [1:0]      wb_sel_q;

    logic [2:0]      op;
    logic [AW-1:0]   tgt;
    logic            expired;

    assign op      = ir_q[ARQ-1 -: 3];
    assign tgt     = ir_q[AW-1:0];
    assign expired = cnt_q == CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
            rf_we_q  <= 1'b0;
            wb_sel_q <= 2'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            mstart_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rf_we_q  <= 1'b0;
            mstart_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        pc_q    <= '0;
                        flag_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (pc_q == AW'(PROG_LEN)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ir_q    <= bus.imem_rdata;
                        pc_q    <= pc_q + AW'(1);
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    // start pulse is registered here so it is high during the EXEC cycle
                    mstart_q <= op == OP_MODEX;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_SET, OP_ADD: begin
                            rf_we_q  <= 1'b1;
                            wb_sel_q <= (op == OP_ADD) ? 2'd1 : 2'd0;
                            state_q  <= WB;
                        end
                        OP_CMPEQ: begin
                            flag_q  <= alu_eq;
                            state_q <= FETCH;
                        end
                        OP_J: begin
                            pc_q    <= tgt;
                            state_q <= FETCH;
                        end
                        OP_JEQ: begin
                            if (flag_q) pc_q <= tgt;
                            state_q <= FETCH;
                        end
                        OP_LDPX, OP_STPX: begin
                            req_q   <= 1'b1;
                            we_q    <= op[1];
                            cnt_q   <= '0;
                            state_q <= MEMW;
                        end
                        default: begin
                            cnt_q   <= '0;
                            state_q <= MODW;
                        end
                    endcase
                end
                MEMW: begin
                    if (bus.dmem_ack) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= FETCH;
                        end else begin
                            rf_we_q  <= 1'b1;
                            wb_sel_q <= 2'd3;
                            state_q  <= WB;
                        end
                    end else if (expired) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MODW: begin
                    if (bus.modex_done) begin
                        rf_we_q  <= 1'b1;
                        wb_sel_q <= 2'd2;
                        state_q  <= WB;
                    end else if (expired) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WB: state_q <= FETCH;
                ERR: state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.dmem_req    = req_q;
    assign bus.dmem_we     = we_q;
    assign bus.modex_start = mstart_q;
    // load data is captured in the very cycle the memory acknowledges
    assign bus.mdr_we      = (state_q == MEMW) && !we_q && bus.dmem_ack;
    assign ir              = ir_q;
    assign rf_we           = rf_we_q;
    assign wb_sel          = wb_sel_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
endmodule

// File: tb/tb_asip_control_unit.sv
// tb_asip_control_unit: table-driven and directed checks of the ASIP control sequencer
module tb_asip_control_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, alu_eq = 1'b0, ack = 1'b0, mdone = 1'b0;
    logic [15:0] rom0 = '0, rom1 = '0;
    logic [15:0] ir;
    logic        rf_we, busy, done, err;
    logic [1:0]  wb_sel;
    logic        t_rst = 1'b1, t_start = 1'b0;
    logic [15:0] t_ir;
    logic        t_rf_we, t_busy, t_done, t_err;
    logic [1:0]  t_wb_sel;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    asip_control_unit_if #(.ARQ(16), .AW(13)) bus ();
    assign bus.imem_rdata = (bus.imem_addr == 13'd0) ? rom0 : (bus.imem_addr == 13'd1) ? rom1 : 16'hC002;
    assign bus.dmem_ack   = ack;
    assign bus.modex_done = mdone;

    asip_control_unit #(.ARQ(16), .AW(13), .PROG_LEN(2), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .ir(ir), .alu_eq(alu_eq),
        .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy), .done(done), .err(err)
    );

    asip_control_unit_if #(.ARQ(16), .AW(13)) tbus ();
    assign tbus.imem_rdata = 16'h2000;
    assign tbus.dmem_ack   = 1'b0;
    assign tbus.modex_done = 1'b0;

    asip_control_unit #(.ARQ(16), .AW(13), .PROG_LEN(2), .TIMEOUT(8)) dut_to (
        .clk(clk), .rst(t_rst), .start(t_start), .bus(tbus), .ir(t_ir), .alu_eq(1'b0),
        .rf_we(t_rf_we), .wb_sel(t_wb_sel), .busy(t_busy), .done(t_done), .err(t_err)
    );

    typedef struct {
        logic [15:0] r0, r1;
        logic        st, eq;
        logic [22:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] snap();
        return {rf_we, wb_sel, bus.dmem_req, bus.dmem_we, bus.mdr_we, bus.modex_start, busy, done, err, bus.imem_addr};
    endfunction

    task automatic add(input logic [15:0] r0, r1, input logic st, eq, input logic [1:0] ws,
                       input logic rf, b, d, input logic [12:0] pc);
        vecs.push_back('{r0, r1, st, eq, {rf, ws, 4'b0000, b, d, 1'b0, pc}});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p1[11] = '{0, 1, 1, 1, 2, 2, 16, 17, 17, 2, 2};
        int p2[8]  = '{0, 1, 1, 1, 2, 2, 2, 2};
        int n, nm, bad;
        // SET r1,#5 ; ADD r1,#3 ; halt
        add(16'h0405, 16'hE403, 1, 0, 0, 0, 1, 0, 0);
        add(16'h0405, 16'hE403, 0, 0, 0, 0, 1, 0, 1);
        add(16'h0405, 16'hE403, 0, 0, 0, 0, 1, 0, 1);
        add(16'h0405, 16'hE403, 0, 0, 0, 1, 1, 0, 1);
        add(16'h0405, 16'hE403, 0, 0, 0, 0, 1, 0, 1);
        add(16'h0405, 16'hE403, 0, 0, 0, 0, 1, 0, 2);
        add(16'h0405, 16'hE403, 0, 0, 0, 0, 1, 0, 2);
        add(16'h0405, 16'hE403, 0, 0, 1, 1, 1, 0, 2);
        add(16'h0405, 16'hE403, 0, 0, 1, 0, 1, 0, 2);
        add(16'h0405, 16'hE403, 0, 0, 1, 0, 0, 1, 2);
        // CMPEQ (eq=1) ; JEQ 0x0010 taken ; ROM[0x10] = J 2 ; halt
        for (int k = 0; k < 11; k++)
            add(16'h8000, 16'hA010, k == 0, 1, 1, 0, k != 10, k == 10, 13'(p1[k]));
        // CMPEQ (eq=0) ; JEQ not taken ; halt
        for (int k = 0; k < 8; k++)
            add(16'h8000, 16'hA010, k == 0, 0, 1, 0, k != 7, k == 7, 13'(p2[k]));

        tick();
        tick();
        chk("reset_outputs", snap(), 0);
        chk("reset_ir", ir, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            rom0   = vecs[k].r0;
            rom1   = vecs[k].r1;
            start  = vecs[k].st;
            alu_eq = vecs[k].eq;
            tick();
            chk($sformatf("vec%0d", k), snap(), vecs[k].exp);
        end
        start  = 1'b0;
        alu_eq = 1'b0;

        // LDPX with ack in the third MEMW cycle, then STPX with immediate ack
        rom0 = 16'h2000;
        rom1 = 16'h6000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        n = 0;
        nm = 0;
        for (int i = 1; i <= 5; i++) begin
            ack = (i == 3);
            #1;
            n += int'(bus.dmem_req);
            nm += int'(bus.mdr_we);
            if (i == 3) begin
                chk("ld_mdr_we", bus.mdr_we, 1);
                chk("ld_dmem_we", bus.dmem_we, 0);
            end
            if (i == 4) chk("ld_wb", {rf_we, wb_sel}, 3'b111);
            tick();
        end
        ack = 1'b0;
        chk("ld_req_cycles", n, 3);
        chk("ld_mdr_pulses", nm, 1);
        tick();
        tick();
        ack = 1'b1;
        #1;
        chk("st_req", bus.dmem_req, 1);
        chk("st_we", bus.dmem_we, 1);
        chk("st_mdr_we", bus.mdr_we, 0);
        tick();
        ack = 1'b0;
        chk("st_req_drop", bus.dmem_req, 0);
        chk("st_no_rf_we", rf_we, 0);
        chk("st_pc", bus.imem_addr, 2);
        wait_done("st_done");

        // MODEX with done on the 50th MODW cycle
        rom0 = 16'h4000;
        rom1 = 16'hC002;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        bad = 0;
        for (int c = 1; c <= 54; c++) begin
            mdone = (c == 53);
            #1;
            n += int'(bus.modex_start);
            if (!busy) bad++;
            if (c == 3) chk("mx_start_exec", bus.modex_start, 1);
            if (c == 54) chk("mx_wb", {rf_we, wb_sel}, 3'b110);
            else if (rf_we) bad++;
            tick();
        end
        mdone = 1'b0;
        chk("mx_start_pulses", n, 1);
        chk("mx_busy_no_early_wb", bad, 0);
        wait_done("mx_done");

        // reset while waiting in MODW
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("pre_modw_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("rst_modw_outputs", snap(), 0);
        chk("rst_modw_ir", ir, 0);
        rst = 1'b0;

        // reset while waiting in MEMW
        rom0 = 16'h2000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_memw_req", bus.dmem_req, 1);
        rst = 1'b1;
        tick();
        chk("rst_memw_outputs", snap(), 0);
        rst = 1'b0;
        rom0 = 16'h0405;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_ir", ir, 16'h0405);
        chk("restart_pc", bus.imem_addr, 1);
        wait_done("restart_done");

        // timeout instance: LDPX never acknowledged
        t_rst = 1'b0;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        tick();
        tick();
        tick();
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (tbus.dmem_req && !t_err) n++;
            tick();
        end
        chk("to_wait_cycles", n, 8);
        chk("to_err", {t_err, tbus.dmem_req, t_busy}, 3'b100);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        tick();
        chk("to_start_ignored", {t_err, t_busy, t_done, tbus.imem_addr}, {3'b100, 13'd1});
        t_rst = 1'b1;
        tick();
        chk("to_rst_clear", {t_err, t_busy, t_done, t_rf_we, tbus.dmem_req, tbus.imem_addr}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
